// File: rtl/pipeline_run_controller_if.sv
// Run/debug control bundle between the run controller and its pipeline/debug host.
// slave is the controller side, master is the host side.
interface pipeline_run_controller_if #(
    parameter int unsigned CNT_WIDTH = 32
) ();
    logic                 i_start;
    logic                 i_step_mode;
    logic                 i_step;
    logic                 i_abort;
    logic                 i_end_detected;
    logic                 i_stall;
    logic                 o_pipe_enable;
    logic                 o_if_enable;
    logic                 o_halt;
    logic                 o_busy;
    logic                 o_done;
    logic [CNT_WIDTH-1:0] o_cycle_count;

    modport master (
        output i_start, i_step_mode, i_step, i_abort, i_end_detected, i_stall,
        input  o_pipe_enable, o_if_enable, o_halt, o_busy, o_done, o_cycle_count
    );

    modport slave (
        input  i_start, i_step_mode, i_step, i_abort, i_end_detected, i_stall,
        output o_pipe_enable, o_if_enable, o_halt, o_busy, o_done, o_cycle_count
    );
endinterface

// File: rtl/pipeline_run_controller.sv
// Run/single-step sequencer for the 5-stage pipeline: gates stage enables,
// freezes fetch on END_INSTR, drains the back end and counts enabled cycles.
module pipeline_run_controller #(
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input logic                      i_clk,
    input logic                      i_reset,
    pipeline_run_controller_if.slave bus
);
    localparam int unsigned DW = (DRAIN_CYCLES == 0) ? 1 : $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_STEP_WAIT,
        S_STEP_EXEC,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t               r_state;
    logic                 r_step_q;
    logic                 r_mode;
    logic [DW-1:0]        r_drain;
    logic [CNT_WIDTH-1:0] r_count;

    logic w_step_pulse;
    logic w_pipe_en;
    logic w_if_en;
    logic w_halt;
    logic w_busy;
    logic w_done;

    assign w_step_pulse = bus.i_step & ~r_step_q;

    // Output decode; fetch enable and step-mode drain enable follow live inputs.
    always_comb begin
        w_pipe_en = 1'b0;
        w_if_en   = 1'b0;
        w_halt    = 1'b0;
        w_busy    = 1'b0;
        w_done    = 1'b0;
        unique case (r_state)
            S_IDLE: ;
            S_RUN, S_STEP_EXEC: begin
                w_pipe_en = 1'b1;
                w_if_en   = ~bus.i_stall & ~bus.i_end_detected;
                w_busy    = 1'b1;
            end
            S_STEP_WAIT: w_busy = 1'b1;
            S_DRAIN: begin
                w_pipe_en = r_mode ? w_step_pulse : 1'b1;
                w_halt    = 1'b1;
                w_busy    = 1'b1;
            end
            S_DONE: begin
                w_halt = 1'b1;
                w_done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state  <= S_IDLE;
            r_step_q <= 1'b0;
            r_mode   <= 1'b0;
            r_drain  <= '0;
            r_count  <= '0;
        end else begin
            r_step_q <= bus.i_step;
            if (w_pipe_en && (r_count != '1)) begin
                r_count <= r_count + CNT_WIDTH'(1);
            end
            if (bus.i_abort) begin
                r_state <= S_IDLE;
                r_drain <= '0;
            end else begin
                unique case (r_state)
                    S_IDLE, S_DONE: begin
                        if (bus.i_start) begin
                            r_mode  <= bus.i_step_mode;
                            r_count <= '0;
                            r_state <= bus.i_step_mode ? S_STEP_WAIT : S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (bus.i_end_detected) begin
                            r_drain <= DW'(DRAIN_CYCLES);
                            r_state <= S_DRAIN;
                        end
                    end
                    S_STEP_WAIT: begin
                        if (w_step_pulse) begin
                            r_state <= S_STEP_EXEC;
                        end
                    end
                    S_STEP_EXEC: begin
                        if (bus.i_end_detected) begin
                            r_drain <= DW'(DRAIN_CYCLES);
                            r_state <= S_DRAIN;
                        end else begin
                            r_state <= S_STEP_WAIT;
                        end
                    end
                    S_DRAIN: begin
                        // Counter of 0 or 1 ends the drain so it can never wrap.
                        if (w_pipe_en) begin
                            if (r_drain <= DW'(1)) begin
                                r_drain <= '0;
                                r_state <= S_DONE;
                            end else begin
                                r_drain <= r_drain - DW'(1);
                            end
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.o_pipe_enable = w_pipe_en;
    assign bus.o_if_enable   = w_if_en;
    assign bus.o_halt        = w_halt;
    assign bus.o_busy        = w_busy;
    assign bus.o_done        = w_done;
    assign bus.o_cycle_count = r_count;
endmodule

// File: doc/pipeline_run_controller.md
Name: pipeline_run_controller

Overview:
- Sequences the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB) for the debug/run infrastructure.
- Starts execution in continuous or single-step mode and gates the per-stage enables.
- On END_INSTR (32'hffffffff) reaching ID, freezes fetch and drives the ID halt input, then drains EX/MEM/WB for a fixed number of cycles.
- Reports completion and an executed-cycle count.

Parameters:
- DRAIN_CYCLES, 4, enabled cycles after END detection before DONE (covers ID->EX->MEM->WB).
- CNT_WIDTH, 32, width of the executed-cycle counter.

Ports:
- i_clk  in  1  clock; all state changes on posedge.
- i_reset  in  1  reset, asynchronous, active-low (0 = reset).
- i_start  in  1  level; sampled in IDLE or DONE to begin a run.
- i_step_mode  in  1  0 = continuous, 1 = single-step; latched when the run starts.
- i_step  in  1  step request; a rising edge is detected internally.
- i_abort  in  1  synchronous abort to IDLE; highest priority.
- i_end_detected  in  1  ID stage currently holds END_INSTR.
- i_stall  in  1  load-use stall from the hazard unit.
- o_pipe_enable  out  1  global enable for the ID/EX/MEM/WB pipeline registers.
- o_if_enable  out  1  enable for the PC and the IF/ID register.
- o_halt  out  1  drives the ID stage i_halt input.
- o_busy  out  1  high in RUN, STEP_WAIT, STEP_EXEC and DRAIN.
- o_done  out  1  high in DONE.
- o_cycle_count  out  CNT_WIDTH  count of cycles with o_pipe_enable = 1.

Behaviour:
- Reset (i_reset = 0, asynchronous):
  - state = IDLE; all outputs 0; o_cycle_count = 0.
  - Drain counter = 0; step edge register = 0; latched mode = 0.
- State encoding and decode:
  - States: IDLE, RUN, STEP_WAIT, STEP_EXEC, DRAIN, DONE.
  - Outputs are Moore decodes of the registered state, except o_if_enable in RUN and STEP_EXEC, and the DRAIN enable.
- Step edge: step_pulse = i_step & ~i_step_q, where i_step_q is registered every cycle.
- IDLE:
  - All enables 0.
  - i_start = 1 -> latch i_step_mode, clear o_cycle_count.
  - Next state is RUN if the mode is 0, STEP_WAIT if it is 1.
- RUN:
  - o_pipe_enable = 1; o_if_enable = ~i_stall & ~i_end_detected.
  - i_end_detected = 1 -> DRAIN with drain counter = DRAIN_CYCLES.
- STEP_WAIT:
  - All enables 0.
  - step_pulse -> STEP_EXEC.
- STEP_EXEC (exactly 1 cycle):
  - o_pipe_enable = 1; o_if_enable = ~i_stall & ~i_end_detected.
  - Next state is DRAIN (counter = DRAIN_CYCLES) if i_end_detected, else STEP_WAIT.
- DRAIN:
  - o_if_enable = 0; o_halt = 1.
  - Continuous mode: o_pipe_enable = 1 every cycle.
  - Step mode: o_pipe_enable = step_pulse.
  - The counter decrements on each enabled cycle.
  - An enabled cycle with counter = 1 -> DONE; the counter never underflows.
- DONE:
  - o_done = 1; enables 0; o_halt = 1, so the END instruction stays held.
  - i_start = 1 -> behaves as IDLE start (relatch mode, clear count).
- i_abort = 1 in any state -> IDLE next cycle; o_cycle_count is retained; the drain counter is cleared.
- o_cycle_count increments by 1 on every cycle with o_pipe_enable = 1 and saturates at all-ones (no wrap).
- Simultaneous events:
  - i_end_detected & i_stall in RUN -> DRAIN; o_if_enable = 0 that cycle.
  - i_start & i_abort -> abort wins.
  - step_pulse in RUN is ignored.
- i_step_mode changes mid-run are ignored until the next start.
- Reset asserted mid-run -> immediate IDLE, all outputs 0.

Test Plan:
- Continuous run, reset released, i_start pulse at cycle 2, i_end_detected high at cycle 10:
  - RUN from cycle 3; DRAIN from cycle 11; o_done at cycle 15.
  - o_cycle_count = 12 (8 RUN + 4 DRAIN cycles).
- Stall in RUN, i_stall = 1 for 2 cycles:
  - o_if_enable = 0 for exactly those 2 cycles; o_pipe_enable stays 1.
  - o_cycle_count still increments on those cycles.
- Step mode, three i_step rising edges with i_step held high 5 cycles each:
  - Exactly 3 STEP_EXEC cycles; o_pipe_enable high 3 cycles total; o_cycle_count = 3.
- Step mode with END during STEP_EXEC:
  - DRAIN needs 4 further step edges; o_done rises the cycle after the 4th.
  - o_halt = 1 throughout DRAIN and DONE.
- i_abort during DRAIN (counter = 2):
  - IDLE next cycle; o_halt = 0; o_done = 0; o_cycle_count is held.
- CNT_WIDTH = 4, run 20 enabled cycles:
  - o_cycle_count saturates at 15.
- i_reset low asynchronously mid-RUN:
  - All outputs 0 before the next clock edge; state is IDLE after release.
